vga_console_ctrl: RTL and testbench

Text-console controller that owns the write port of the VGA character memory (29 rows x 69 cols). It takes a valid/ready stream of characters and colours, interprets control codes, and tracks the cursor. It implements hardware scrolling through a circular row-base offset that the display side adds to its row index, and performs full-screen and single-line clears by sequencing writes.

---
 rtl/vga_console_pkg.sv | 25 ++
 rtl/vga_console_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants and types for the VGA text-console controller.
package vga_console_pkg;

  localparam int unsigned COLS_DEF = 69;
  localparam int unsigned ROWS_DEF = 29;
  localparam int unsigned ROW_W    = 5;
  localparam int unsigned COL_W    = 7;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ALL,
    CLEAR_LINE
  } state_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= 8'h20) && (ch <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_console_ctrl.sv
// Text-console controller: owns the character-memory write port, interprets
// control codes, tracks the cursor and scrolls via a circular row base.
module vga_console_ctrl
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter logic [2:0]  CLR_FG = 3'b111,
  parameter logic [2:0]  CLR_BG = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic [2:0]       in_fg,
  input  logic [2:0]       in_bg,
  output logic             we,
  output logic [ROW_W-1:0] wr_addr,
  output logic [COL_W-1:0] wc_addr,
  output logic [7:0]       w_ascii,
  output logic [2:0]       w_fg_color,
  output logic [2:0]       w_bg_color,
  output logic [ROW_W-1:0] row_base,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy
);

  localparam logic [ROW_W-1:0] LastRow  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LastCol  = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]   RowsWide = (ROW_W + 1)'(ROWS);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_base_q, row_base_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic             we_q, we_d;
  logic [ROW_W-1:0] wr_addr_q, wr_addr_d;
  logic [COL_W-1:0] wc_addr_q, wc_addr_d;
  logic [7:0]       w_ascii_q, w_ascii_d;
  logic [2:0]       w_fg_q, w_fg_d;
  logic [2:0]       w_bg_q, w_bg_d;

  logic [ROW_W:0]   phys_sum;
  logic [ROW_W-1:0] phys_row;
  logic             line_adv;

  // Physical row of the cursor: both operands are below ROWS, so one
  // conditional subtract is enough for the modulo.
  always_comb begin
    phys_sum = {1'b0, row_base_q} + {1'b0, cur_row_q};
    if (phys_sum >= RowsWide) begin
      phys_row = ROW_W'(phys_sum - RowsWide);
    end else begin
      phys_row = phys_sum[ROW_W-1:0];
    end
  end

  // Next-state, cursor and write-port decisions.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    row_base_d = row_base_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wc_addr_d  = wc_addr_q;
    w_ascii_d  = w_ascii_q;
    w_fg_d     = w_fg_q;
    w_bg_d     = w_bg_q;
    line_adv   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            we_d      = 1'b1;
            wr_addr_d = phys_row;
            wc_addr_d = cur_col_q;
            w_ascii_d = in_char;
            w_fg_d    = in_fg;
            w_bg_d    = in_bg;
            if (cur_col_q == LastCol) begin
              cur_col_d = '0;
              line_adv  = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end else begin
            case (in_char)
              CH_LF: begin
                cur_col_d = '0;
                line_adv  = 1'b1;
              end
              CH_CR: cur_col_d = '0;
              CH_BS: begin
                // No reverse wrap at column 0.
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - 1'b1;
                  we_d      = 1'b1;
                  wr_addr_d = phys_row;
                  wc_addr_d = cur_col_q - 1'b1;
                  w_ascii_d = CH_SP;
                  w_fg_d    = CLR_FG;
                  w_bg_d    = CLR_BG;
                end
              end
              CH_FF: begin
                row_base_d = '0;
                cur_row_d  = '0;
                cur_col_d  = '0;
                row_cnt_d  = '0;
                col_cnt_d  = '0;
                state_d    = CLEAR_ALL;
              end
              default: ;
            endcase
          end

          if (line_adv) begin
            if (cur_row_q != LastRow) begin
              cur_row_d = cur_row_q + 1'b1;
            end else begin
              // Scroll: the old top row becomes the new bottom row and is blanked.
              row_base_d = (row_base_q == LastRow) ? '0 : row_base_q + 1'b1;
              row_cnt_d  = row_base_q;
              col_cnt_d  = '0;
              state_d    = CLEAR_LINE;
            end
          end
        end
      end

      CLEAR_ALL: begin
        we_d      = 1'b1;
        wr_addr_d = row_cnt_q;
        wc_addr_d = col_cnt_q;
        w_ascii_d = CH_SP;
        w_fg_d    = CLR_FG;
        w_bg_d    = CLR_BG;
        if (col_cnt_q == LastCol) begin
          col_cnt_d = '0;
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end

      CLEAR_LINE: begin
        we_d      = 1'b1;
        wr_addr_d = row_cnt_q;
        wc_addr_d = col_cnt_q;
        w_ascii_d = CH_SP;
        w_fg_d    = CLR_FG;
        w_bg_d    = CLR_BG;
        if (col_cnt_q == LastCol) begin
          col_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered write port; reset restarts the full-screen clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ALL;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      row_base_q <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wc_addr_q  <= '0;
      w_ascii_q  <= CH_SP;
      w_fg_q     <= CLR_FG;
      w_bg_q     <= CLR_BG;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      row_base_q <= row_base_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wc_addr_q  <= wc_addr_d;
      w_ascii_q  <= w_ascii_d;
      w_fg_q     <= w_fg_d;
      w_bg_q     <= w_bg_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign we         = we_q;
  assign wr_addr    = wr_addr_q;
  assign wc_addr    = wc_addr_q;
  assign w_ascii    = w_ascii_q;
  assign w_fg_color = w_fg_q;
  assign w_bg_color = w_bg_q;
  assign row_base   = row_base_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Self-checking bench for vga_console_ctrl: a logical-screen model (rows shift
// on scroll) is compared against a memory rebuilt from the DUT write port.
module tb_vga_console_ctrl;
  import vga_console_pkg::*;

  localparam int ROWS = 29;
  localparam int COLS = 69;
  localparam logic [13:0] BLANK = {3'b000, 3'b111, 8'h20};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic [2:0] in_fg = 3'd0;
  logic [2:0] in_bg = 3'd0;
  logic       in_ready, we, busy;
  logic [4:0] wr_addr, row_base, cur_row;
  logic [6:0] wc_addr, cur_col;
  logic [7:0] w_ascii;
  logic [2:0] w_fg_color, w_bg_color;

  vga_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_fg      (in_fg),
    .in_bg      (in_bg),
    .we         (we),
    .wr_addr    (wr_addr),
    .wc_addr    (wc_addr),
    .w_ascii    (w_ascii),
    .w_fg_color (w_fg_color),
    .w_bg_color (w_bg_color),
    .row_base   (row_base),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] dut_mem [ROWS][COLS];
  logic [13:0] scr     [ROWS][COLS];
  int m_row, m_col, m_rb;

  // Rebuild character memory from the write port.
  always @(negedge clk) begin
    if (we === 1'b1 && int'(wr_addr) < ROWS && int'(wc_addr) < COLS)
      dut_mem[int'(wr_addr)][int'(wc_addr)] = {w_bg_color, w_fg_color, w_ascii};
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    m_rb = 0; m_row = 0; m_col = 0;
  endtask

  task automatic m_advance(output bit scrolled);
    scrolled = 1'b0;
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
      m_rb = (m_rb + 1) % ROWS;
      scrolled = 1'b1;
    end
  endtask

  // kind: 0 = stays idle, 1 = full clear, 2 = scroll line clear
  task automatic m_step(input logic [7:0] ch, input logic [2:0] fg, input logic [2:0] bg,
                        output bit w, output int wrow, output int wcol,
                        output logic [13:0] wdata, output int kind, output int old_rb);
    bit sc;
    sc = 1'b0; w = 1'b0; wrow = 0; wcol = 0; wdata = '0; kind = 0; old_rb = m_rb;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      w = 1'b1; wrow = (m_rb + m_row) % ROWS; wcol = m_col; wdata = {bg, fg, ch};
      scr[m_row][m_col] = wdata;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_advance(sc);
      end
    end else if (ch == CH_LF) begin
      m_col = 0;
      m_advance(sc);
    end else if (ch == CH_CR) begin
      m_col = 0;
    end else if (ch == CH_BS) begin
      if (m_col > 0) begin
        m_col--;
        w = 1'b1; wrow = (m_rb + m_row) % ROWS; wcol = m_col; wdata = BLANK;
        scr[m_row][m_col] = BLANK;
      end
    end else if (ch == CH_FF) begin
      m_reset();
      kind = 1;
    end
    if (sc) kind = 2;
  endtask

  // ---------------- stimulus / checking helpers ----------------
  task automatic sweep(input int n, input int row0, input string name);
    int errs, rdy_errs;
    logic [25:0] exp_a;
    errs = 0; rdy_errs = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_a = {5'(row0 + k / COLS), 7'(k % COLS), BLANK};
      if (we !== 1'b1 || {wr_addr, wc_addr, w_bg_color, w_fg_color, w_ascii} !== exp_a) errs++;
      if (in_ready !== (k == n - 1)) rdy_errs++;
      if (busy !== (k != n - 1)) rdy_errs++;
    end
    chk({name, "_writes"}, 64'(errs), 64'd0);
    chk({name, "_ready"}, 64'(rdy_errs), 64'd0);
  endtask

  task automatic send(input logic [7:0] ch, input logic [2:0] fg, input logic [2:0] bg,
                      input bit keep);
    int guard, wrow, wcol, kind, old_rb;
    bit w;
    logic [13:0] wdata;
    logic [26:0] exp_w, act_w;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1; in_char = ch; in_fg = fg; in_bg = bg;
    m_step(ch, fg, bg, w, wrow, wcol, wdata, kind, old_rb);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    exp_w = w ? {1'b1, 5'(wrow), 7'(wcol), wdata} : 27'd0;
    act_w = {we, (we === 1'b1) ? {wr_addr, wc_addr, w_bg_color, w_fg_color, w_ascii} : 26'd0};
    chk("write", 64'(act_w), 64'(exp_w));
    chk("cursor", {in_ready, row_base, cur_row, cur_col},
        {(kind == 0), 5'(m_rb), 5'(m_row), 7'(m_col)});
    if (kind == 1) sweep(ROWS * COLS, 0, "ff_clear");
    else if (kind == 2) sweep(COLS, old_rb, "scroll_clear");
  endtask

  task automatic do_reset(input string name);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_state"},
        {we, in_ready, busy, row_base, cur_row, cur_col, wr_addr, wc_addr, w_ascii,
         w_fg_color, w_bg_color},
        {1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 7'd0, 8'h20, 3'b111, 3'b000});
    rst = 1'b0;  // this cycle is C0
    m_reset();
    sweep(ROWS * COLS, 0, name);
    chk({name, "_rb"}, 64'(row_base), 64'd0);
  endtask

  task automatic check_screen(input string name);
    int bad;
    bad = 0;
    #1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (dut_mem[(m_rb + r) % ROWS][c] !== scr[r][c]) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  ch;
    logic [2:0]  fg;
    logic [2:0]  bg;
    logic        exp_we;
    logic [6:0]  exp_wcol;
    logic [13:0] exp_data;
    logic [4:0]  exp_row;
    logic [6:0]  exp_col;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int r;
    logic [7:0] ch;

    vecs[0]  = '{8'h41, 3'd2, 3'd1, 1'b1, 7'd0, {3'd1, 3'd2, 8'h41}, 5'd0, 7'd1};
    vecs[1]  = '{8'h42, 3'd5, 3'd3, 1'b1, 7'd1, {3'd3, 3'd5, 8'h42}, 5'd0, 7'd2};
    vecs[2]  = '{8'h01, 3'd0, 3'd0, 1'b0, 7'd0, 14'd0,                5'd0, 7'd2};
    vecs[3]  = '{8'h7F, 3'd1, 3'd1, 1'b0, 7'd0, 14'd0,                5'd0, 7'd2};
    vecs[4]  = '{8'h7E, 3'd6, 3'd0, 1'b1, 7'd2, {3'd0, 3'd6, 8'h7E}, 5'd0, 7'd3};
    vecs[5]  = '{8'h08, 3'd1, 3'd2, 1'b1, 7'd2, BLANK,                5'd0, 7'd2};
    vecs[6]  = '{8'h0D, 3'd0, 3'd0, 1'b0, 7'd0, 14'd0,                5'd0, 7'd0};
    vecs[7]  = '{8'h08, 3'd0, 3'd0, 1'b0, 7'd0, 14'd0,                5'd0, 7'd0};
    vecs[8]  = '{8'h0A, 3'd0, 3'd0, 1'b0, 7'd0, 14'd0,                5'd1, 7'd0};
    vecs[9]  = '{8'h20, 3'd4, 3'd4, 1'b1, 7'd0, {3'd4, 3'd4, 8'h20}, 5'd1, 7'd1};
    vecs[10] = '{8'hFF, 3'd7, 3'd7, 1'b0, 7'd0, 14'd0,                5'd1, 7'd1};
    vecs[11] = '{8'h1B, 3'd0, 3'd0, 1'b0, 7'd0, 14'd0,                5'd1, 7'd1};

    repeat (2) @(negedge clk);
    do_reset("por");
    check_screen("por_screen");

    foreach (vecs[i]) begin
      send(vecs[i].ch, vecs[i].fg, vecs[i].bg, 1'b0);
      chk($sformatf("vec%0d_wr", i),
          {we, (we === 1'b1) ? {wc_addr, w_bg_color, w_fg_color, w_ascii} : 21'd0},
          {vecs[i].exp_we, vecs[i].exp_wcol, vecs[i].exp_data});
      chk($sformatf("vec%0d_cur", i), {cur_row, cur_col}, {vecs[i].exp_row, vecs[i].exp_col});
    end

    // Full line of printables wraps to the next row without scrolling.
    send(CH_CR, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < COLS; i++) send(8'(8'h21 + i), 3'(i), 3'(i + 3), 1'b0);
    chk("row_wrap", {in_ready, wc_addr, cur_row, cur_col}, {1'b1, 7'd68, 5'd2, 7'd0});

    while (m_row < ROWS - 1) send(CH_LF, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 3'd3, 3'd2, 1'b0);
    send(CH_BS, 3'd0, 3'd0, 1'b0);
    chk("bs_col5", {we, wc_addr, w_ascii, cur_col}, {1'b1, 7'd4, 8'h20, 7'd4});
    send(CH_CR, 3'd0, 3'd0, 1'b0);

    // Scroll from row 28 with row_base 0.
    send(CH_LF, 3'd0, 3'd0, 1'b0);
    chk("scroll_rb", {row_base, cur_row, cur_col}, {5'd1, 5'd28, 7'd0});

    // Held valid during a scroll is consumed only once ready returns.
    send(CH_LF, 3'd0, 3'd0, 1'b1);
    send(CH_LF, 3'd0, 3'd0, 1'b0);
    chk("held_rb", 64'(row_base), 64'd3);
    check_screen("scroll_screen");

    // Reset in the middle of a line clear with row_base 27.
    while (m_rb != 26) send(CH_LF, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1; in_char = CH_LF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_rb", 64'(row_base), 64'd27);
    repeat (10) @(negedge clk);
    chk("mid_scroll_busy", {in_ready, busy}, 2'b01);
    do_reset("mid_rst");
    check_screen("mid_rst_screen");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      ch = 8'($urandom_range(32, 126));
      else if (r < 82) ch = CH_LF;
      else if (r < 86) ch = CH_CR;
      else if (r < 93) ch = CH_BS;
      else if (r < 94) ch = CH_FF;
      else if (r < 97) ch = 8'($urandom_range(0, 31));
      else             ch = 8'($urandom_range(127, 255));
      send(ch, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    check_screen("rand_screen");
    chk("rand_cursor", {row_base, cur_row, cur_col}, {5'(m_rb), 5'(m_row), 7'(m_col)});

    // Form feed with row_base 10.
    send(CH_FF, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < ROWS - 1 + 10; i++) send(CH_LF, 3'd0, 3'd0, 1'b0);
    chk("ff_pre_rb", 64'(row_base), 64'd10);
    send(8'h5A, 3'd1, 3'd6, 1'b0);
    send(CH_FF, 3'd0, 3'd0, 1'b0);
    chk("ff_post", {in_ready, row_base, cur_row, cur_col}, {1'b1, 5'd0, 5'd0, 7'd0});
    check_screen("ff_screen");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
